// File: rtl/uart_rx_ext.sv
// UART receiver with optional parity, 1/2 stop bits and a valid/ready output holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_ext #(
  parameter int unsigned DBIT = 8,
  parameter int unsigned OVS  = 16,
  parameter int unsigned SB   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      par_mode,
  output logic [DBIT-1:0] dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun
);

  localparam int unsigned SW = $clog2(OVS);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
  // Start decision moves one tick later so its 3-tick window straddles mid-bit.
  localparam logic [SW-1:0] S_START = SW'(OVS / 2);
`else
  localparam logic [SW-1:0] S_START = SW'(OVS / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_n;
  logic [SW-1:0]   s_q, s_n;
  logic [NW-1:0]   n_q, n_n;
  logic [DBIT-1:0] b_q, b_n;
  logic [1:0]      pm_q, pm_n;
  logic            perr_q, perr_n;
  logic            ferr_q, ferr_n;
  logic            rx_q1, rx_s;
  logic            samp_c;
  logic            done_c;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Last two s_tick samples; majority with the current sample rejects one-tick glitches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= 2'b11;
    end else if (s_tick) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign samp_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign samp_c = rx_s;
`endif

  // FSM state and frame datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      pm_q    <= 2'b00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      n_q     <= n_n;
      b_q     <= b_n;
      pm_q    <= pm_n;
      perr_q  <= perr_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    n_n     = n_q;
    b_n     = b_q;
    pm_n    = pm_q;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
          n_n     = '0;
          pm_n    = par_mode;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_START) begin
            s_n = '0;
            n_n = '0;
            state_n = samp_c ? IDLE : DATA;
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_n = '0;
            b_n = {samp_c, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              n_n     = '0;
              state_n = (pm_q == 2'b01 || pm_q == 2'b10) ? PARITY : STOP;
            end else begin
              n_n = n_q + NW'(1);
            end
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_n     = '0;
            n_n     = '0;
            // Even mode flags an odd total; odd mode flags an even total.
            perr_n  = (^b_q) ^ samp_c ^ (pm_q == 2'b10);
            state_n = STOP;
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_END) begin
            s_n    = '0;
            ferr_n = ferr_q | ~samp_c;
            if (n_q == NW'(SB - 1)) begin
              n_n     = '0;
              state_n = IDLE;
              done_c  = 1'b1;
            end else begin
              n_n = n_q + NW'(1);
            end
          end else begin
            s_n = s_q + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output holding register with valid/ready handshake; a full register drops the new frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout         <= '0;
      out_valid    <= 1'b0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_done_tick <= done_c;
      overrun      <= 1'b0;
      if (done_c) begin
        if (!out_valid || out_ready) begin
          dout       <= b_q;
          parity_err <= perr_q;
          frame_err  <= ferr_n;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext (DBIT=8, OVS=16, SB=1); expectations track UART_RX_MAJORITY_EN.
module tb_uart_rx_ext;

  localparam int unsigned OVS = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       s_tick;
  logic [1:0] par_mode;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  uart_rx_ext #(.DBIT(8), .OVS(OVS), .SB(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .par_mode     (par_mode),
    .dout         (dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Monitor-owned observation log; the stimulus process only reads it.
  logic [7:0] obs_d  [32];
  logic       obs_pe [32];
  logic       obs_fe [32];
  int         obs_wr = 0;
  int         n_done = 0;
  int         n_ovr  = 0;
  int         rd     = 0;

  always @(negedge clk) begin
    if (rx_done_tick) n_done <= n_done + 1;
    if (overrun) n_ovr <= n_ovr + 1;
    if (out_valid && out_ready && obs_wr < 32) begin
      obs_d[obs_wr]  <= dout;
      obs_pe[obs_wr] <= parity_err;
      obs_fe[obs_wr] <= frame_err;
      obs_wr         <= obs_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One oversample period: rx settles through the synchronizer before s_tick fires.
  task automatic slot(input logic v);
    rx     = v;
    s_tick = 1'b0;
    repeat (3) step();
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
  endtask

  function automatic logic exp_pe(input logic [7:0] d, input logic [1:0] pm, input logic pbit);
    if (pm == 2'b01) return (^d) ^ pbit;
    if (pm == 2'b10) return ~((^d) ^ pbit);
    return 1'b0;
  endfunction

  // glitch_k >= 0 pulls data bit glitch_k low for the single tick at its nominal sample point.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic stop_v, input int glitch_k, input int idle);
    par_mode = pm;
    for (int i = 0; i < OVS; i++) slot(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < OVS; i++)
        slot((b == glitch_k && i == OVS / 2 - 1) ? 1'b0 : d[b]);
    if (pm == 2'b01 || pm == 2'b10)
      for (int i = 0; i < OVS; i++) slot(pbit);
    // A low stop bit is released early so its tail is not mistaken for a new start bit.
    for (int i = 0; i < OVS; i++) slot((!stop_v && i >= OVS / 2 + 2) ? 1'b1 : stop_v);
    for (int i = 0; i < idle; i++) slot(1'b1);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic compare_obs();
    exp_t e;
    while (rd < obs_wr) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {24'h0, obs_d[rd]}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("dout", {24'h0, obs_d[rd]}, {24'h0, e.d});
        check("parity_err", {31'h0, obs_pe[rd]}, {31'h0, e.pe});
        check("frame_err", {31'h0, obs_fe[rd]}, {31'h0, e.fe});
      end
      rd++;
    end
  endtask

  int         d0;
  int         o0;
  logic [7:0] gl_exp;

  initial begin
    reset_n   = 1'b0;
    rx        = 1'b1;
    s_tick    = 1'b0;
    par_mode  = 2'b00;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_flags", {27'h0, out_valid, rx_done_tick, parity_err, frame_err, overrun}, 32'h0);
    reset_n = 1'b1;
    repeat (4) slot(1'b1);

    // Plain 8N1 frame
    d0 = n_done;
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, -1, 2);
    compare_obs();
    check("done_once_55", n_done - d0, 1);

    // Short low pulse on idle line is rejected
    d0 = n_done;
    for (int i = 0; i < 4; i++) slot(1'b0);
    for (int i = 0; i < 20; i++) slot(1'b1);
    check("glitch_no_done", n_done - d0, 0);
    check("glitch_no_valid", {31'h0, out_valid}, 32'h0);

    // Parity modes: even bad, even good, odd good, mode 11 as none
    push(8'hA3, exp_pe(8'hA3, 2'b01, 1'b1), 1'b0);
    send_frame(8'hA3, 2'b01, 1'b1, 1'b1, -1, 2);
    push(8'hA3, exp_pe(8'hA3, 2'b01, 1'b0), 1'b0);
    send_frame(8'hA3, 2'b01, 1'b0, 1'b1, -1, 2);
    push(8'h07, exp_pe(8'h07, 2'b10, 1'b0), 1'b0);
    send_frame(8'h07, 2'b10, 1'b0, 1'b1, -1, 2);
    push(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, 2'b11, 1'b0, 1'b1, -1, 2);
    compare_obs();

    // Framing error
    push(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, -1, 2);
    compare_obs();

    // Back-to-back frames with no idle gap
    d0 = n_done;
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, -1, 0);
    push(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, -1, 2);
    compare_obs();
    check("done_b2b", n_done - d0, 2);

    // One-tick glitch on data bit 3 at its sample point
`ifdef UART_RX_MAJORITY_EN
    gl_exp = 8'hFF;
`else
    gl_exp = 8'hF7;
`endif
    push(gl_exp, 1'b0, 1'b0);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1, 3, 2);
    compare_obs();

    // Overrun: held word survives, second frame dropped
    out_ready = 1'b0;
    o0 = n_ovr;
    d0 = n_done;
    push(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, -1, 2);
    send_frame(8'h22, 2'b00, 1'b0, 1'b1, -1, 2);
    check("overrun_once", n_ovr - o0, 1);
    check("done_during_ovr", n_done - d0, 2);
    check("held_dout", {24'h0, dout}, 32'h11);
    out_ready = 1'b1;
    step();
    compare_obs();
    check("valid_clr", {31'h0, out_valid}, 32'h0);

    // Reset mid-frame with a word held
    out_ready = 1'b0;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, -1, 2);
    check("pre_rst_dout", {24'h0, dout}, 32'h5A);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < OVS; i++) slot(1'b0);
    for (int i = 0; i < 40; i++) slot(i[4]);
    reset_n = 1'b0;
    rx      = 1'b1;
    step();
    check("mid_rst_dout", {24'h0, dout}, 32'h0);
    check("mid_rst_flags", {27'h0, out_valid, rx_done_tick, parity_err, frame_err, overrun}, 32'h0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    d0 = n_done;
    repeat (4) slot(1'b1);
    push(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, -1, 4);
    compare_obs();
    check("done_after_rst", n_done - d0, 1);

    check("missing_words", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
